// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared types and constants for the increment pipeline and its issue arbiter
package lu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } lu_state_e;

  localparam int LU_AW         = 8;
  localparam int LU_PIPE_DEPTH = 4;

endpackage

// File: rtl/lu_issue_arbiter_if.sv
// rtl/lu_issue_arbiter_if.sv - requester handshake and pipeline issue bundle
interface lu_issue_arbiter_if
  import lu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = LU_AW,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      icode;
  logic               icode_vld;
  logic [IDW-1:0]     grant_id;

  modport master (
    output req_valid, req_addr,
    input  req_ready, icode, icode_vld, grant_id
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, icode, icode_vld, grant_id
  );

endinterface

// File: rtl/lu_rr_picker.sv
// rtl/lu_rr_picker.sv - combinational round-robin pick starting at the pointer, ascending with wrap
module lu_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/lu_issue_arbiter.sv
// rtl/lu_issue_arbiter.sv - round-robin issue of requester addresses into the increment pipeline
// with in-flight tracking and a drain/pause handshake for quiescing before readback.
module lu_issue_arbiter
  import lu_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int AW         = LU_AW,
  parameter int PIPE_DEPTH = LU_PIPE_DEPTH,
  parameter int CNT_W      = 16,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  lu_issue_arbiter_if.slave bus,
  input  logic              drain_req,
  output logic              drain_done,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_cnt
);

  lu_state_e             state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [PIPE_DEPTH-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]         icode_q, icode_d;
  logic                  vld_q, vld_d;
  logic [IDW-1:0]        gid_q, gid_d;

  logic [NREQ-1:0]       pick_gnt;
  logic [IDW-1:0]        pick_idx;
  logic                  pick_vld;
  logic                  arb_en;
  logic                  xfer;
  logic                  busy_w;

  lu_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // drain_req gates the grant in the same cycle it rises, before the state register sees it
  assign arb_en        = (state_q == RUN) && !drain_req;
  assign xfer          = arb_en && pick_vld;
  assign bus.req_ready = arb_en ? pick_gnt : '0;
  assign busy_w        = vld_q || (|inflight_q);

  assign bus.icode     = icode_q;
  assign bus.icode_vld = vld_q;
  assign bus.grant_id  = gid_q;
  assign drain_done    = (state_q == PAUSED);
  assign busy          = busy_w;
  assign issue_cnt     = cnt_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    icode_d    = icode_q;
    gid_d      = gid_q;
    vld_d      = xfer;
    inflight_d = (inflight_q << 1) | PIPE_DEPTH'(vld_q);

    case (state_q)
      RUN:     if (drain_req)  state_d = DRAIN;
      DRAIN:   if (!busy_w)    state_d = PAUSED;
      PAUSED:  if (!drain_req) state_d = RUN;
      default:                 state_d = RUN;
    endcase

    if (xfer) begin
      ptr_d   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
      icode_d = bus.req_addr[pick_idx*AW +: AW];
      gid_d   = pick_idx;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      ptr_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      icode_q    <= '0;
      vld_q      <= 1'b0;
      gid_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      icode_q    <= icode_d;
      vld_q      <= vld_d;
      gid_q      <= gid_d;
    end
  end

endmodule

// File: tb/tb_lu_issue_arbiter.sv
// tb/tb_lu_issue_arbiter.sv - self-checking bench for lu_issue_arbiter against a cycle-level reference model
module tb_lu_issue_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 8;
  localparam int PD    = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain_req = 1'b0;
  logic drain_done, busy;
  logic [CNT_W-1:0] issue_cnt;

  logic drain_req4 = 1'b0;
  logic drain_done4, busy4;
  logic [3:0] issue_cnt4;

  lu_issue_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();
  lu_issue_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus4 ();

  lu_issue_arbiter #(.NREQ(NREQ), .AW(AW), .PIPE_DEPTH(PD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .busy       (busy),
    .issue_cnt  (issue_cnt)
  );

  lu_issue_arbiter #(.NREQ(NREQ), .AW(AW), .PIPE_DEPTH(PD), .CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus4),
    .drain_req  (drain_req4),
    .drain_done (drain_done4),
    .busy       (busy4),
    .issue_cnt  (issue_cnt4)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] addr [NREQ];

  // reference model state
  int            cyc = 0;
  int            m_ptr = 0;
  int            m_mode = 0;      // 0 run, 1 draining, 2 paused
  int            m_last = -1000;  // edge index of the most recent issue
  int            m_cnt = 0;
  logic [AW-1:0] m_icode = '0;
  logic          m_vld = 1'b0;
  int            m_gid = 0;
  logic [NREQ-1:0] exp_ready, obs_ready;

  function automatic bit m_busy();
    return (cyc - m_last) <= PD;
  endfunction

  task automatic drive(input logic [NREQ-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = addr[i];
  endtask

  // one clock: sample combinational ready mid-cycle, advance the model at the edge
  task automatic tick();
    int g;
    bit bz;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g  = -1;
    er = '0;
    if (m_mode == 0 && !drain_req)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    if (g >= 0) er[g] = 1'b1;
    exp_ready = er;
    obs_ready = bus.req_ready;
    bz = m_busy();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_ptr = 0; m_mode = 0; m_last = -1000; m_cnt = 0;
      m_icode = '0; m_vld = 1'b0; m_gid = 0;
    end else begin
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_icode = bus.req_addr[g*AW +: AW];
        m_gid   = g;
        m_ptr   = (g + 1) % NREQ;
        m_last  = cyc;
        if (m_cnt < CMAX) m_cnt++;
      end
      case (m_mode)
        0: if (drain_req) m_mode = 1;
        1: if (!bz) m_mode = 2;
        default: if (!drain_req) m_mode = 0;
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drain_req = 1'b0;
    for (int i = 0; i < NREQ; i++) addr[i] = 8'($urandom);
    for (int c = 0; c < 6; c++) begin
      drive(4'($urandom));
      tick();
    end
    drive(4'b1111);
    drain_req = 1'b1;
    tick();
    tick();
    drain_req = 1'b0;
    do_reset();
    n_vec++; if (bus.icode_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", bus.icode_vld); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (issue_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", issue_cnt); end
    n_vec++; if (drain_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", drain_done); end
    n_vec++; if (bus.icode !== '0 || bus.grant_id !== '0) begin n_bad++; $display("FAIL reset_icode: got %h/%0d want 0/0", bus.icode, bus.grant_id); end
    tick();
    n_vec++; if (obs_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_idle_ready: got %b want 0000", obs_ready); end
    drive(4'b1111);
    tick();
    n_vec++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_ptr: got %b want 0001", obs_ready); end
    n_vec++; if (bus.grant_id !== 2'd0 || bus.icode_vld !== 1'b1) begin n_bad++; $display("FAIL reset_first_gid: got %0d/%b want 0/1", bus.grant_id, bus.icode_vld); end
  endtask

  task automatic test_single();
    do_reset();
    addr[2] = 8'h3C;
    drive(4'b0100);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (obs_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready c%0d: got %b want 0100", c, obs_ready); end
      n_vec++; if (bus.icode_vld !== 1'b1 || bus.icode !== 8'h3C || bus.grant_id !== 2'd2) begin
        n_bad++; $display("FAIL single_issue c%0d: got %b/%h/%0d want 1/3c/2", c, bus.icode_vld, bus.icode, bus.grant_id); end
    end
    n_vec++; if (issue_cnt !== 16'd3) begin n_bad++; $display("FAIL single_cnt: got %0d want 3", issue_cnt); end
    drive('0);
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < NREQ; i++) addr[i] = 8'(8'h10 + i);
    drive(4'b1111);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++; if (!$onehot(obs_ready) || obs_ready !== 4'(1 << (c % 4))) begin
        n_bad++; $display("FAIL rot_ready c%0d: got %b want %b", c, obs_ready, 4'(1 << (c % 4))); end
      n_vec++; if (bus.grant_id !== 2'(c % 4) || bus.icode !== 8'(8'h10 + c % 4)) begin
        n_bad++; $display("FAIL rot_issue c%0d: got %0d/%h want %0d/%h", c, bus.grant_id, bus.icode, c % 4, 8'h10 + c % 4); end
    end
    drive('0);
    tick();
  endtask

  task automatic test_drain();
    int fb, fd;
    do_reset();
    addr[0] = 8'h21; addr[1] = 8'h22;
    drive(4'b0011);
    for (int c = 0; c < 5; c++) tick();   // grants 0,1,0,1,0 leave the pointer at 1
    drain_req = 1'b1;
    fb = -1; fd = -1;
    for (int c = 1; c <= 20 && fd < 0; c++) begin
      tick();
      n_vec++; if (obs_ready !== 4'b0000) begin n_bad++; $display("FAIL drain_ready c%0d: got %b want 0000", c, obs_ready); end
      n_vec++; if (busy !== m_busy() || drain_done !== (m_mode == 2)) begin
        n_bad++; $display("FAIL drain_status c%0d: got %b/%b want %b/%b", c, busy, drain_done, m_busy(), m_mode == 2); end
      if (fb < 0 && !busy) fb = c;
      if (fd < 0 && drain_done) fd = c;
    end
    n_vec++; if (fb != PD + 1) begin n_bad++; $display("FAIL drain_busy_fall: got %0d want %0d", fb, PD + 1); end
    n_vec++; if (fd != PD + 2) begin n_bad++; $display("FAIL drain_done_time: got %0d want %0d (timeout if -1)", fd, PD + 2); end
    drain_req = 1'b0;
    tick();
    n_vec++; if (drain_done !== 1'b0) begin n_bad++; $display("FAIL drain_exit: got %b want 0", drain_done); end
    drive(4'b1111);
    tick();
    n_vec++; if (obs_ready !== 4'b0010) begin n_bad++; $display("FAIL drain_ptr_kept: got %b want 0010", obs_ready); end
    drive('0);
    tick();
  endtask

  task automatic test_gaps();
    bit hit;
    do_reset();
    addr[1] = 8'hAB;
    for (int c = 0; c < 8; c++) begin
      hit = (c == 0 || c == 2 || c == 5);
      drive(hit ? 4'b0010 : 4'b0000);
      tick();
      n_vec++; if (bus.icode_vld !== hit || bus.icode !== 8'hAB) begin
        n_bad++; $display("FAIL gaps c%0d: got %b/%h want %b/ab", c + 1, bus.icode_vld, bus.icode, hit); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) == 0) addr[i] = 8'($urandom);
      if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
      drive(4'($urandom));
      tick();
      n_vec++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
      n_vec++; if (bus.icode_vld !== m_vld || bus.icode !== m_icode || bus.grant_id !== 2'(m_gid)) begin
        n_bad++; $display("FAIL rnd_issue c%0d: got %b/%h/%0d want %b/%h/%0d", c, bus.icode_vld, bus.icode, bus.grant_id, m_vld, m_icode, m_gid); end
      n_vec++; if (busy !== m_busy() || drain_done !== (m_mode == 2) || issue_cnt !== 16'(m_cnt)) begin
        n_bad++; $display("FAIL rnd_status c%0d: got %b/%b/%0d want %b/%b/%0d", c, busy, drain_done, issue_cnt, m_busy(), m_mode == 2, m_cnt); end
    end
    drain_req = 1'b0;
    drive('0);
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_saturate();
    do_reset();
    bus4.req_valid = 4'b0001;
    bus4.req_addr  = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      n_vec++; if (issue_cnt4 !== 4'((c < 15) ? c : 15)) begin
        n_bad++; $display("FAIL sat_cnt c%0d: got %0d want %0d", c, issue_cnt4, (c < 15) ? c : 15); end
    end
    bus4.req_valid = '0;
  endtask

  initial begin
    bus4.req_valid = '0;
    bus4.req_addr  = '0;
    for (int i = 0; i < NREQ; i++) addr[i] = '0;
    drive('0);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_drain();
    test_gaps();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
